apb_master_ctrl: RTL and testbench

APB master sequencer between the processor-side request bus and the two APB slave ports (apb1/apb2) of the APB block.
- Accepts one request at a time from the processor and decodes the target slave by comparing sel against the slave ids id1/id2.
- Runs the APB SETUP/ACCESS handshake, returns read data, and signals completion on stable.
- Slave-side outputs are broadcast to both slaves; only the decoded slave's ready/rdata is observed.

---
 rtl/apb_master_ctrl_if.sv | 44 ++++
 rtl/apb_master_ctrl.sv | 168 ++++++++++++++++
 tb/tb_apb_master_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_ctrl_if.sv
// apb_master_ctrl_if: processor request bus plus the broadcast APB slave-side signals.
// The master modport is the sequencer's view; the slave modport is the view of whatever
// sits around it (processor and the two APB slaves).
interface apb_master_ctrl_if;
  // Processor side
  logic       start;
  logic       p_write;
  logic [1:0] p_sel;
  logic [7:0] p_addr;
  logic [7:0] p_wdata;
  logic [7:0] p_wait_cycles;
  logic [7:0] p_rdata;
  logic       stable;
  logic       busy;
  logic       error;
  // Slave ids used for target decode
  logic [1:0] id1;
  logic [1:0] id2;
  // APB side, broadcast to both slaves
  logic       m_write;
  logic [1:0] m_sel;
  logic [7:0] m_addr;
  logic [7:0] m_wdata;
  logic       m_enable;
  logic [7:0] m_wait_cycles;
  logic       ready1;
  logic [7:0] rdata1;
  logic       ready2;
  logic [7:0] rdata2;

  modport master (
    input  start, p_write, p_sel, p_addr, p_wdata, p_wait_cycles, id1, id2,
    input  ready1, rdata1, ready2, rdata2,
    output p_rdata, stable, busy, error,
    output m_write, m_sel, m_addr, m_wdata, m_enable, m_wait_cycles
  );

  modport slave (
    output start, p_write, p_sel, p_addr, p_wdata, p_wait_cycles, id1, id2,
    output ready1, rdata1, ready2, rdata2,
    input  p_rdata, stable, busy, error,
    input  m_write, m_sel, m_addr, m_wdata, m_enable, m_wait_cycles
  );
endinterface

// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: single-outstanding APB master sequencer.
// Accepts a processor request in IDLE, decodes the target slave against id1/id2, runs the
// SETUP/ACCESS handshake and reports completion with a one-cycle stable pulse.
// Optional feature: define APB_TIMEOUT_EN to abort an ACCESS phase once TIMEOUT cycles of
// target ready low have elapsed (error pulse with stable). Default build waits forever.
module apb_master_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input logic               clk,
  input logic               reset,
  apb_master_ctrl_if.master bus_io
);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StAccess,
    StDone,
    StFail
  } state_e;

  state_e     state_q, state_d;
  logic       write_q, write_d;
  logic [1:0] sel_q, sel_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] wait_q, wait_d;
  logic [7:0] rdata_q, rdata_d;
  // 1: slave 1 is the target of the transfer in flight, 0: slave 2
  logic       tgt1_q, tgt1_d;

  logic       req_valid;
  logic       id_hit;
  logic       tgt_ready;
  logic [7:0] tgt_rdata;
  logic       in_xfer;

  if (TIMEOUT == 0) begin : g_bad_timeout
    $error("apb_master_ctrl: TIMEOUT must be >= 1");
  end

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_hit;

  // This ready-low cycle is the TIMEOUT-th one spent in ACCESS.
  assign timeout_hit = (cnt_q == CntW'(TIMEOUT - 1));
`endif

  // Request decode; a p_sel of zero never addresses anything.
  assign req_valid = bus_io.start && (bus_io.p_sel != 2'b00);
  assign id_hit    = (bus_io.p_sel == bus_io.id1) || (bus_io.p_sel == bus_io.id2);

  // Only the latched target's handshake is observed.
  assign tgt_ready = tgt1_q ? bus_io.ready1 : bus_io.ready2;
  assign tgt_rdata = tgt1_q ? bus_io.rdata1 : bus_io.rdata2;

  // Next-state and register-load logic.
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wait_d  = wait_q;
    rdata_d = rdata_q;
    tgt1_d  = tgt1_q;
`ifdef APB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (id_hit) begin
            state_d = StSetup;
            write_d = bus_io.p_write;
            sel_d   = bus_io.p_sel;
            addr_d  = bus_io.p_addr;
            wdata_d = bus_io.p_wdata;
            wait_d  = bus_io.p_wait_cycles;
            // id1 is checked first so it wins when both ids are equal
            tgt1_d  = (bus_io.p_sel == bus_io.id1);
          end else begin
            state_d = StFail;
          end
        end
      end

      StSetup: begin
        state_d = StAccess;
`ifdef APB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end

      StAccess: begin
        // Ready in the same cycle as the timeout still completes normally.
        if (tgt_ready) begin
          state_d = StDone;
          if (!write_q) begin
            rdata_d = tgt_rdata;
          end
`ifdef APB_TIMEOUT_EN
        end else if (timeout_hit) begin
          state_d = StFail;
        end else begin
          cnt_d = cnt_q + CntW'(1);
`endif
        end
      end

      StDone:  state_d = StIdle;
      StFail:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and transfer registers; reset aborts any transfer without a completion pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      write_q <= 1'b0;
      sel_q   <= 2'b00;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      wait_q  <= 8'h00;
      rdata_q <= 8'h00;
      tgt1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wait_q  <= wait_d;
      rdata_q <= rdata_d;
      tgt1_q  <= tgt1_d;
    end
  end

`ifdef APB_TIMEOUT_EN
  // ACCESS wait counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // Outputs decode straight from state so reset forces them low immediately.
  assign in_xfer              = (state_q == StSetup) || (state_q == StAccess);
  assign bus_io.busy          = in_xfer;
  assign bus_io.m_enable      = (state_q == StAccess);
  assign bus_io.m_sel         = in_xfer ? sel_q : 2'b00;
  assign bus_io.stable        = (state_q == StDone) || (state_q == StFail);
  assign bus_io.error         = (state_q == StFail);
  assign bus_io.m_write       = write_q;
  assign bus_io.m_addr        = addr_q;
  assign bus_io.m_wdata       = wdata_q;
  assign bus_io.m_wait_cycles = wait_q;
  assign bus_io.p_rdata       = rdata_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb_apb_master_ctrl: directed table, corner sequences and randomized transfers for
// apb_master_ctrl. A reactive slave model drives ready/rdata; expected latency, error and
// read data come from a transaction-level model of the request rules.
module tb_apb_master_ctrl;

  localparam int unsigned TO = 16;

  logic clk;
  logic reset;

  apb_master_ctrl_if bus ();

  apb_master_ctrl #(
    .TIMEOUT(TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus_io(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;
  logic [7:0] model_prd;

  typedef struct {
    logic [1:0] i1;
    logic [1:0] i2;
    logic       wr;
    logic [1:0] sel;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] wt;
    logic [7:0] rdv;
    int         dly;
    bit         hold;
    int         lat;
    bit         err;
    logic [7:0] prd;
  } vec_t;

  vec_t tbl[10];

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chk_8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int tgt_of(input logic [1:0] i1, input logic [1:0] i2,
                                input logic [1:0] sel);
    if (sel == 2'b00) return 0;
    if (sel == i1) return 1;
    if (sel == i2) return 2;
    return 0;
  endfunction

  // Cycles from start to stable: miss = 1, otherwise SETUP + ACCESS cycles + 1.
  function automatic int model_lat(input int tgt, input int dly);
    if (tgt == 0) return 1;
`ifdef APB_TIMEOUT_EN
    if (dly >= int'(TO)) return int'(TO) + 2;
`endif
    return dly + 3;
  endfunction

  function automatic bit model_err(input int tgt, input int dly);
    if (tgt == 0) return 1'b1;
`ifdef APB_TIMEOUT_EN
    if (dly >= int'(TO)) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // One request, issued at a sample point in IDLE. The target holds ready low for dly
  // ACCESS cycles. hold keeps start asserted through the stable cycle.
  task automatic do_txn(input logic [1:0] i1, input logic [1:0] i2, input logic wr,
                        input logic [1:0] sel, input logic [7:0] addr, input logic [7:0] wdata,
                        input logic [7:0] wt, input logic [7:0] rdv, input int dly,
                        input bit hold, input int exp_lat, input bit exp_err,
                        input logic [7:0] exp_prd);
    int   tgt;
    int   cyc;
    int   en_cnt;
    int   lat;
    bit   bus_ok;
    bit   quiet_ok;
    bit   err_ok;
    bit   setup_ok;
    logic r;
    tgt      = tgt_of(i1, i2, sel);
    cyc      = 0;
    en_cnt   = 0;
    lat      = 0;
    bus_ok   = 1'b1;
    quiet_ok = 1'b1;
    err_ok   = 1'b1;
    setup_ok = 1'b1;
    bus.id1           = i1;
    bus.id2           = i2;
    bus.start         = 1'b1;
    bus.p_write       = wr;
    bus.p_sel         = sel;
    bus.p_addr        = addr;
    bus.p_wdata       = wdata;
    bus.p_wait_cycles = wt;
    bus.ready1        = 1'b0;
    bus.ready2        = 1'b0;
    bus.rdata1        = (tgt == 1) ? rdv : ~rdv;
    bus.rdata2        = (tgt == 2) ? rdv : ~rdv;
    while (lat == 0 && cyc < exp_lat + 8) begin
      @(posedge clk);
      #1;
      cyc++;
      // Processor inputs wander after accept; they must not disturb the transfer.
      bus.start         = hold;
      bus.p_sel         = hold ? sel : 2'($urandom);
      bus.p_write       = 1'($urandom);
      bus.p_addr        = 8'($urandom);
      bus.p_wdata       = 8'($urandom);
      bus.p_wait_cycles = 8'($urandom);
      if (bus.stable) begin
        lat = cyc;
        chk_b("stable_error", bus.error, exp_err);
        chk_b("stable_busy", bus.busy, 1'b0);
        chk_b("stable_enable", bus.m_enable, 1'b0);
        chk_8("stable_msel", 8'(bus.m_sel), 8'h00);
        bus.ready1 = 1'b0;
        bus.ready2 = 1'b0;
      end else begin
        if (bus.error) err_ok = 1'b0;
        if (tgt == 0) begin
          if (bus.m_enable || bus.m_sel != 2'b00) quiet_ok = 1'b0;
        end else begin
          if (!bus.busy) bus_ok = 1'b0;
          if (cyc == 1 && bus.m_enable) setup_ok = 1'b0;
          if (cyc >= 2 && !bus.m_enable) setup_ok = 1'b0;
          if (bus.m_sel != sel || bus.m_addr != addr || bus.m_write != wr ||
              bus.m_wdata != wdata || bus.m_wait_cycles != wt) bus_ok = 1'b0;
          if (bus.m_enable) en_cnt++;
          r = bus.m_enable && (en_cnt > dly);
          if (tgt == 1) begin
            bus.ready1 = r;
            bus.ready2 = 1'($urandom);
          end else begin
            bus.ready2 = r;
            bus.ready1 = 1'($urandom);
          end
        end
      end
    end
    chk_i("latency", lat, exp_lat);
    chk_i("enable_cycles", en_cnt, (tgt == 0) ? 0 : exp_lat - 2);
    chk_8("p_rdata", bus.p_rdata, exp_prd);
    chk_b("no_early_error", err_ok, 1'b1);
    if (tgt == 0) begin
      chk_b("fail_apb_quiet", quiet_ok, 1'b1);
    end else begin
      chk_b("apb_bus_held", bus_ok, 1'b1);
      chk_b("setup_access_phase", setup_ok, 1'b1);
    end
    @(posedge clk);
    #1;
    chk_b("post_busy", bus.busy, 1'b0);
    chk_b("post_stable", bus.stable, 1'b0);
    bus.start  = 1'b0;
    bus.ready1 = 1'b0;
    bus.ready2 = 1'b0;
  endtask

  task automatic rnd_txn(input logic [1:0] i1, input logic [1:0] i2, input logic wr,
                         input logic [1:0] sel, input logic [7:0] rdv, input int dly,
                         input bit hold);
    int tgt;
    bit err;
    tgt = tgt_of(i1, i2, sel);
    err = model_err(tgt, dly);
    if (!err && !wr) model_prd = rdv;
    do_txn(i1, i2, wr, sel, 8'($urandom), 8'($urandom), 8'($urandom), rdv, dly, hold,
           model_lat(tgt, dly), err, model_prd);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    bit quiet;
    n_checks          = 0;
    n_errors          = 0;
    model_prd         = 8'h00;
    reset             = 1'b0;
    bus.start         = 1'b0;
    bus.p_write       = 1'b0;
    bus.p_sel         = 2'b00;
    bus.p_addr        = 8'h00;
    bus.p_wdata       = 8'h00;
    bus.p_wait_cycles = 8'h00;
    bus.id1           = 2'd1;
    bus.id2           = 2'd2;
    bus.ready1        = 1'b0;
    bus.ready2        = 1'b0;
    bus.rdata1        = 8'h00;
    bus.rdata2        = 8'h00;

    //                i1    i2    wr    sel   addr   wdata  wt     rdv    dly hold  lat err   prd
    tbl[0] = '{2'd1, 2'd2, 1'b0, 2'd1, 8'h10, 8'h00, 8'h00, 8'hA5, 0, 1'b0, 3, 1'b0, 8'hA5};
    tbl[1] = '{2'd1, 2'd2, 1'b1, 2'd2, 8'h24, 8'h3C, 8'h03, 8'h77, 4, 1'b0, 7, 1'b0, 8'hA5};
    tbl[2] = '{2'd1, 2'd2, 1'b0, 2'd3, 8'h30, 8'h00, 8'h00, 8'h99, 0, 1'b0, 1, 1'b1, 8'hA5};
    tbl[3] = '{2'd1, 2'd2, 1'b0, 2'd2, 8'h20, 8'h00, 8'h01, 8'h5A, 1, 1'b1, 4, 1'b0, 8'h5A};
    tbl[4] = '{2'd1, 2'd2, 1'b0, 2'd1, 8'h44, 8'h00, 8'h02, 8'hC3, 2, 1'b1, 5, 1'b0, 8'hC3};
    tbl[5] = '{2'd1, 2'd2, 1'b1, 2'd1, 8'h55, 8'hE7, 8'h00, 8'h00, 0, 1'b1, 3, 1'b0, 8'hC3};
    tbl[6] = '{2'd1, 2'd2, 1'b0, 2'd3, 8'h66, 8'h00, 8'h00, 8'h12, 0, 1'b1, 1, 1'b1, 8'hC3};
    tbl[7] = '{2'd2, 2'd2, 1'b0, 2'd2, 8'h77, 8'h00, 8'h00, 8'h11, 0, 1'b0, 3, 1'b0, 8'h11};
    tbl[8] = '{2'd2, 2'd1, 1'b0, 2'd1, 8'h88, 8'h00, 8'h05, 8'h6B, 3, 1'b0, 6, 1'b0, 8'h6B};
    tbl[9] = '{2'd3, 2'd1, 1'b0, 2'd3, 8'h99, 8'h00, 8'h00, 8'h4D, 0, 1'b0, 3, 1'b0, 8'h4D};

    // Reset state, checked while reset is held and again after release.
    repeat (2) @(posedge clk);
    #1;
    chk_8("rst_p_rdata", bus.p_rdata, 8'h00);
    chk_8("rst_m_sel", 8'(bus.m_sel), 8'h00);
    chk_b("rst_m_enable", bus.m_enable, 1'b0);
    chk_b("rst_stable", bus.stable, 1'b0);
    chk_b("rst_busy", bus.busy, 1'b0);
    chk_b("rst_error", bus.error, 1'b0);
    chk_8("rst_m_addr", bus.m_addr, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_b("idle_busy", bus.busy, 1'b0);
    chk_b("idle_stable", bus.stable, 1'b0);

    // start with p_sel 0 is ignored even when an id is 0.
    bus.id1   = 2'd0;
    bus.id2   = 2'd2;
    bus.start = 1'b1;
    bus.p_sel = 2'b00;
    quiet     = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.busy || bus.stable || bus.error || bus.m_sel != 2'b00) quiet = 1'b0;
    end
    chk_b("sel0_ignored", quiet, 1'b1);
    bus.start = 1'b0;

    for (int i = 0; i < 10; i++) begin
      do_txn(tbl[i].i1, tbl[i].i2, tbl[i].wr, tbl[i].sel, tbl[i].addr, tbl[i].wdata,
             tbl[i].wt, tbl[i].rdv, tbl[i].dly, tbl[i].hold, tbl[i].lat, tbl[i].err,
             tbl[i].prd);
      model_prd = tbl[i].prd;
    end

`ifdef APB_TIMEOUT_EN
    // Ready never arrives: abort after TO ACCESS cycles.
    do_txn(2'd1, 2'd2, 1'b0, 2'd1, 8'h31, 8'h00, 8'h00, 8'hEE, 1000, 1'b0,
           int'(TO) + 2, 1'b1, model_prd);
    // Ready arrives on the TO-th ACCESS cycle: normal completion.
    do_txn(2'd1, 2'd2, 1'b0, 2'd2, 8'h32, 8'h00, 8'h00, 8'h3E, int'(TO) - 1, 1'b0,
           int'(TO) + 2, 1'b0, 8'h3E);
    model_prd = 8'h3E;
`else
    // Without the timeout a long wait still completes cleanly.
    do_txn(2'd1, 2'd2, 1'b0, 2'd1, 8'h31, 8'h00, 8'h00, 8'h3E, 25, 1'b0, 28, 1'b0, 8'h3E);
    model_prd = 8'h3E;
`endif

    for (int k = 0; k < 40; k++) begin
      logic [1:0] i1;
      logic [1:0] i2;
      logic [1:0] sel;
      int         dly;
      i1  = 2'($urandom_range(1, 3));
      i2  = 2'($urandom_range(0, 3));
      sel = 2'($urandom_range(1, 3));
      dly = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 5));
      rnd_txn(i1, i2, 1'($urandom), sel, 8'($urandom_range(1, 255)), dly, 1'($urandom));
    end

    // Reset during ACCESS: outputs drop at once, no stable pulse.
    do_txn(2'd1, 2'd2, 1'b0, 2'd1, 8'h40, 8'h00, 8'h00, 8'hF0, 0, 1'b0, 3, 1'b0, 8'hF0);
    bus.id1    = 2'd1;
    bus.id2    = 2'd2;
    bus.start  = 1'b1;
    bus.p_write = 1'b0;
    bus.p_sel  = 2'd1;
    bus.p_addr = 8'h42;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    chk_b("pre_reset_enable", bus.m_enable, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk_b("async_rst_enable", bus.m_enable, 1'b0);
    chk_8("async_rst_msel", 8'(bus.m_sel), 8'h00);
    chk_b("async_rst_busy", bus.busy, 1'b0);
    chk_8("async_rst_p_rdata", bus.p_rdata, 8'h00);
    model_prd  = 8'h00;
    bus.ready1 = 1'b1;
    bus.rdata1 = 8'h77;
    quiet      = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.stable || bus.busy) quiet = 1'b0;
    end
    @(negedge clk);
    reset      = 1'b1;
    bus.ready1 = 1'b0;
    @(posedge clk);
    #1;
    if (bus.stable || bus.busy) quiet = 1'b0;
    chk_b("no_stable_after_reset", quiet, 1'b1);
    do_txn(2'd1, 2'd2, 1'b0, 2'd2, 8'h50, 8'h00, 8'h00, 8'h6C, 1, 1'b0, 4, 1'b0, 8'h6C);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
